// File: rtl/pad_owner_arbiter_if.sv
// Bundle of requester-side and pad-side signals for pad_owner_arbiter.
// The arbiter connects through the slave modport; the requesters and pad ring use master.
interface pad_owner_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PAD_W   = 4
);
    localparam int unsigned OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ*PAD_W-1:0] oe_i;
    logic [NUM_REQ*PAD_W-1:0] out_i;
    logic [PAD_W-1:0]         in_o;
    logic [PAD_W-1:0]         pad_oen_o;
    logic [PAD_W-1:0]         pad_out_o;
    logic [PAD_W-1:0]         pad_in_i;
    logic [OWNER_W-1:0]       owner_o;
    logic                     busy_o;
    logic                     timeout_o;

    modport master (
        output req_i, oe_i, out_i, pad_in_i,
        input  gnt_o, in_o, pad_oen_o, pad_out_o, owner_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, oe_i, out_i, pad_in_i,
        output gnt_o, in_o, pad_oen_o, pad_out_o, owner_o, busy_o, timeout_o
    );
endinterface

// File: rtl/pad_owner_arbiter.sv
// Round-robin ownership arbiter for a shared pad group with enforced tristate turnaround.
// Define PAD_OWNER_ARBITER_TIMEOUT_EN to revoke a grant held too long under contention.
module pad_owner_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned PAD_W          = 4,
    parameter int unsigned TURNAROUND     = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pad_owner_arbiter_if.slave   bus
);
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t                              state;
    logic [NUM_REQ-1:0]                  gnt;
    logic [NUM_REQ-1:0]                  eligible;
    logic [NUM_REQ-1:0]                  others;
    logic [OW-1:0]                       owner;
    logic [OW-1:0]                       winner;
    logic [OW-1:0]                       cand;
    logic                                found;
    logic                                busy;
    logic                                timeout;
    logic [CW-1:0]                       cnt;
    logic [PAD_W-1:0]                    own_oe;
    logic [PAD_W-1:0]                    own_out;
    logic [SYNC_STAGES-1:0][PAD_W-1:0]   sync_q;

`ifdef PAD_OWNER_ARBITER_TIMEOUT_EN
    localparam int unsigned HW = $clog2(TIMEOUT_CYCLES + 1);
    logic [NUM_REQ-1:0] mask;
    logic [HW-1:0]      hold;
    assign eligible = bus.req_i & ~mask;
`else
    assign eligible = bus.req_i;
    assign timeout  = 1'b0;
`endif

    // Owner slice select; also strips the owner from the contention view
    always_comb begin
        own_oe  = '0;
        own_out = '0;
        others  = bus.req_i;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (owner == OW'(r)) begin
                own_oe    = bus.oe_i[r*PAD_W +: PAD_W];
                own_out   = bus.out_i[r*PAD_W +: PAD_W];
                others[r] = 1'b0;
            end
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = owner;
        cand   = owner;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((32'(owner) + i) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= OW'(NUM_REQ - 1);
            busy  <= 1'b0;
            cnt   <= '0;
`ifdef PAD_OWNER_ARBITER_TIMEOUT_EN
            mask    <= '0;
            hold    <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef PAD_OWNER_ARBITER_TIMEOUT_EN
            timeout <= 1'b0;
            mask    <= mask & bus.req_i;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        owner       <= winner;
                        gnt[winner] <= 1'b1;
                        state       <= GRANT;
                        busy        <= 1'b1;
`ifdef PAD_OWNER_ARBITER_TIMEOUT_EN
                        hold        <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req_i[owner]) begin
                        gnt   <= '0;
                        state <= TURN;
                        cnt   <= CW'(TURNAROUND - 1);
                    end
`ifdef PAD_OWNER_ARBITER_TIMEOUT_EN
                    else if (|others) begin
                        if (hold == HW'(TIMEOUT_CYCLES - 1)) begin
                            gnt         <= '0;
                            state       <= TURN;
                            cnt         <= CW'(TURNAROUND - 1);
                            timeout     <= 1'b1;
                            mask[owner] <= 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
`endif
                end
                TURN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_in_i};
        end
    end

    // Drive comes straight from the owner slice; reset forces IDLE and thus tristate
    assign bus.pad_oen_o = (state == GRANT) ? ~own_oe : '1;
    assign bus.pad_out_o = (state == GRANT) ? (own_out & own_oe) : '0;
    assign bus.gnt_o     = gnt;
    assign bus.owner_o   = owner;
    assign bus.busy_o    = busy;
    assign bus.timeout_o = timeout;
    assign bus.in_o      = sync_q[SYNC_STAGES-1];
endmodule
